// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns level read/write requests into a strobe/ack bus transaction,
// holds the last read word and stalls the control unit through oRdy until the bus completes.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic        oRdy,
  output logic [31:0] oData,
  output logic        oErr,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWrData,
  output logic        oMemRd,
  output logic        oMemWr,
  input  logic        iMemAck,
  input  logic [31:0] iMemRdData
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic [31:0] r_data, w_data_d;
  logic        r_err, w_err_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic        r_rd, w_rd_d;
  logic        r_wr, w_wr_d;
  logic        w_timeout;

  // The timeout fires on the edge that would end the TIMEOUT-th wait cycle.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TIMEOUT - 32'd1);

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_data  <= w_data_d;
      r_err   <= w_err_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_rd    <= w_rd_d;
      r_wr    <= w_wr_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_data_d  = r_data;
    w_err_d   = r_err;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_rd_d    = r_rd;
    w_wr_d    = r_wr;
    unique case (r_state)
      StIdle: begin
        // Write wins when both requests are raised together.
        if (iWr) begin
          w_addr_d  = iAddr;
          w_wdata_d = iWrData;
          w_wr_d    = 1'b1;
          w_err_d   = 1'b0;
          w_cnt_d   = '0;
          w_state_d = StWrWait;
        end else if (iRd) begin
          w_addr_d  = iAddr;
          w_rd_d    = 1'b1;
          w_err_d   = 1'b0;
          w_cnt_d   = '0;
          w_state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (iMemAck) begin
          w_data_d  = iMemRdData;
          w_rd_d    = 1'b0;
          w_state_d = StDone;
        end else if (w_timeout) begin
          w_data_d  = 32'hFFFF_FFFF;
          w_err_d   = 1'b1;
          w_rd_d    = 1'b0;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + 32'd1;
        end
      end
      StWrWait: begin
        if (iMemAck) begin
          w_wr_d    = 1'b0;
          w_state_d = StDone;
        end else if (w_timeout) begin
          w_err_d   = 1'b1;
          w_wr_d    = 1'b0;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + 32'd1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign oRdy       = ((r_state == StIdle) && !iRd && !iWr) || (r_state == StDone);
  assign oData      = r_data;
  assign oErr       = r_err;
  assign oMemAddr   = r_addr;
  assign oMemWrData = r_wdata;
  assign oMemRd     = r_rd;
  assign oMemWr     = r_wr;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl (TIMEOUT=4); inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_mem_bus_ctrl;

  logic        iClk;
  logic        nRst;
  logic        iRd;
  logic        iWr;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic        oRdy;
  logic [31:0] oData;
  logic        oErr;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWrData;
  logic        oMemRd;
  logic        oMemWr;
  logic        iMemAck;
  logic [31:0] iMemRdData;

  int n_pass;
  int n_tot;

  mem_bus_ctrl #(
    .TIMEOUT(4)
  ) dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .iRd       (iRd),
    .iWr       (iWr),
    .iAddr     (iAddr),
    .iWrData   (iWrData),
    .oRdy      (oRdy),
    .oData     (oData),
    .oErr      (oErr),
    .oMemAddr  (oMemAddr),
    .oMemWrData(oMemWrData),
    .oMemRd    (oMemRd),
    .oMemWr    (oMemWr),
    .iMemAck   (iMemAck),
    .iMemRdData(iMemRdData)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0;
    n_tot = 0;
    nRst = 1'b0;
    iRd = 1'b0;
    iWr = 1'b0;
    iAddr = '0;
    iWrData = '0;
    iMemAck = 1'b0;
    iMemRdData = '0;
    #2;
    chk("rst_rdy", 32'(oRdy), 32'd1);
    chk("rst_data", oData, 32'h0);
    chk("rst_err", 32'(oErr), 32'd0);
    chk("rst_addr", oMemAddr, 32'h0);
    chk("rst_wdata", oMemWrData, 32'h0);
    chk("rst_strobes", {30'd0, oMemRd, oMemWr}, 32'd0);
    @(negedge iClk);
    nRst = 1'b1;
    step();

    // Read, zero-wait
    iRd = 1'b1;
    iAddr = 32'h100;
    #1;
    chk("rd0_rdy_req", 32'(oRdy), 32'd0);
    step();
    chk("rd0_strobe", 32'(oMemRd), 32'd1);
    chk("rd0_addr", oMemAddr, 32'h100);
    chk("rd0_rdy_wait", 32'(oRdy), 32'd0);
    iMemAck = 1'b1;
    iMemRdData = 32'hDEAD_BEEF;
    step();
    iMemAck = 1'b0;
    chk("rd0_strobe_drop", 32'(oMemRd), 32'd0);
    chk("rd0_rdy_done", 32'(oRdy), 32'd1);
    chk("rd0_data", oData, 32'hDEAD_BEEF);
    chk("rd0_err", 32'(oErr), 32'd0);
    step();
    iRd = 1'b0;
    #1;
    chk("rd0_rdy_idle", 32'(oRdy), 32'd1);

    // Write, 3 wait states; ack lands on the timeout edge, so ack wins
    iWr = 1'b1;
    iAddr = 32'h200;
    iWrData = 32'h1234_5678;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_strobe_%0d", i), 32'(oMemWr), 32'd1);
      if (i == 3) iMemAck = 1'b1;
      else step();
    end
    chk("wr_wdata", oMemWrData, 32'h1234_5678);
    chk("wr_addr", oMemAddr, 32'h200);
    step();
    iMemAck = 1'b0;
    chk("wr_strobe_drop", 32'(oMemWr), 32'd0);
    chk("wr_rdy_done", 32'(oRdy), 32'd1);
    chk("wr_err", 32'(oErr), 32'd0);
    chk("wr_data_hold", oData, 32'hDEAD_BEEF);
    step();
    iWr = 1'b0;

    // Read timeout
    iRd = 1'b1;
    iAddr = 32'h300;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_strobe_%0d", i), 32'(oMemRd), 32'd1);
      step();
    end
    chk("to_strobe_drop", 32'(oMemRd), 32'd0);
    chk("to_err", 32'(oErr), 32'd1);
    chk("to_data", oData, 32'hFFFF_FFFF);
    chk("to_rdy_done", 32'(oRdy), 32'd1);
    step();
    iRd = 1'b0;
    #1;
    chk("to_err_sticky", 32'(oErr), 32'd1);

    // Following read clears oErr
    iRd = 1'b1;
    iAddr = 32'h304;
    step();
    chk("clr_err_accept", 32'(oErr), 32'd0);
    iMemAck = 1'b1;
    iMemRdData = 32'hCAFE_F00D;
    step();
    iMemAck = 1'b0;
    chk("clr_data", oData, 32'hCAFE_F00D);
    chk("clr_err", 32'(oErr), 32'd0);
    step();
    iRd = 1'b0;

    // Simultaneous read and write: write priority
    iRd = 1'b1;
    iWr = 1'b1;
    iAddr = 32'h400;
    iWrData = 32'h55AA_55AA;
    step();
    chk("both_wr", 32'(oMemWr), 32'd1);
    chk("both_rd", 32'(oMemRd), 32'd0);
    iMemAck = 1'b1;
    iMemRdData = 32'h9999_9999;
    step();
    iMemAck = 1'b0;
    chk("both_data_hold", oData, 32'hCAFE_F00D);
    chk("both_wdata", oMemWrData, 32'h55AA_55AA);
    step();
    iRd = 1'b0;
    iWr = 1'b0;

    // Read with ack on the timeout edge
    iRd = 1'b1;
    iAddr = 32'h500;
    step();
    step();
    step();
    step();
    iMemAck = 1'b1;
    iMemRdData = 32'h0BAD_F00D;
    step();
    iMemAck = 1'b0;
    chk("ackto_err", 32'(oErr), 32'd0);
    chk("ackto_data", oData, 32'h0BAD_F00D);
    chk("ackto_wdata_hold", oMemWrData, 32'h55AA_55AA);
    step();
    iRd = 1'b0;

    // Back-to-back reads: request held through DONE
    iRd = 1'b1;
    iAddr = 32'h600;
    step();
    iMemAck = 1'b1;
    iMemRdData = 32'h1111_1111;
    step();
    iMemAck = 1'b0;
    iAddr = 32'h604;
    chk("b2b_first_data", oData, 32'h1111_1111);
    step();
    chk("b2b_idle_rdy", 32'(oRdy), 32'd0);
    chk("b2b_idle_strobe", 32'(oMemRd), 32'd0);
    step();
    chk("b2b_second_strobe", 32'(oMemRd), 32'd1);
    chk("b2b_second_addr", oMemAddr, 32'h604);
    iMemAck = 1'b1;
    iMemRdData = 32'h2222_2222;
    step();
    iMemAck = 1'b0;
    chk("b2b_second_data", oData, 32'h2222_2222);
    step();
    iRd = 1'b0;

    // Spurious ack in IDLE
    iMemAck = 1'b1;
    iMemRdData = 32'h3333_3333;
    step();
    iMemAck = 1'b0;
    chk("spur_data", oData, 32'h2222_2222);
    chk("spur_strobe", 32'(oMemRd), 32'd0);
    step();
    chk("spur_rdy", 32'(oRdy), 32'd1);

    // Reset mid RD_WAIT
    iRd = 1'b1;
    iAddr = 32'h700;
    step();
    chk("rst_mid_strobe_pre", 32'(oMemRd), 32'd1);
    #2;
    nRst = 1'b0;
    #1;
    chk("rst_mid_strobe", 32'(oMemRd), 32'd0);
    chk("rst_mid_data", oData, 32'h0);
    chk("rst_mid_addr", oMemAddr, 32'h0);
    iRd = 1'b0;
    #1;
    chk("rst_mid_rdy", 32'(oRdy), 32'd1);
    @(negedge iClk);
    nRst = 1'b1;
    step();
    iRd = 1'b1;
    iAddr = 32'h800;
    step();
    chk("post_rst_strobe", 32'(oMemRd), 32'd1);
    iMemAck = 1'b1;
    iMemRdData = 32'h4444_4444;
    step();
    iMemAck = 1'b0;
    chk("post_rst_data", oData, 32'h4444_4444);
    chk("post_rst_err", 32'(oErr), 32'd0);
    chk("post_rst_rdy", 32'(oRdy), 32'd1);
    step();
    iRd = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
